// File: rtl/mcu_multicycle.sv
// Multi-cycle main control unit: Moore FSM sequencing MIPS instructions over a
// shared ready-handshake memory port, with a memory-wait watchdog.
//
// state    | meaning
// FETCH    | read instruction at PC; load IR and PC+4 when memory is ready
// DECODE   | latch opcode, precompute branch target
// MEM_ADDR | compute load/store effective address
// MEM_RD   | data read, wait for memory
// MEM_WB   | write loaded data to rt
// MEM_WR   | data write, wait for memory
// EXEC     | ALU operation for R-type / immediate / LUI
// ALU_WB   | write ALU result to rd (R-type) or rt
// BRANCH   | compare operands, conditional PC write with branch target
// JUMP     | PC <- jump target
// JAL_WB   | $31 <- PC, PC <- jump target
// FAULT    | watchdog expiry or illegal opcode, held until reset
module mcu_multicycle #(
  parameter int ALUOP_W = 4,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op_code,
  input  logic               mem_ready,
  output logic               PCWr,
  output logic               PCWrCond,
  output logic [1:0]         PCSrc,
  output logic               IorD,
  output logic               IRWr,
  output logic               MemRd,
  output logic               MemWr,
  output logic               MemtoReg,
  output logic [1:0]         RegDst,
  output logic               RegWr,
  output logic               RegPCWr,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               sigext_high,
  output logic               fault,
  output logic [3:0]         state_o
);

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_R    = ALUOP_W'(8);

  localparam logic [5:0] OP_RR    = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TMO_MAX);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_JAL_WB   = 4'd10,
    S_FAULT    = 4'd11
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [5:0]       op_q;
  logic [TMO_W-1:0] tmo;
  logic [TMO_W-1:0] tmo_nx;
  logic             wait_st;
  logic             tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      op_q  <= 6'b000000;
      tmo   <= '0;
    end else begin
      state <= state_nx;
      tmo   <= tmo_nx;
      if (state == S_DECODE) begin
        op_q <= op_code;
      end
    end
  end

  assign wait_st = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign tmo_hit = (tmo == TMO_LIMIT);

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)    state_nx = S_DECODE;
        else if (tmo_hit) state_nx = S_FAULT;
      end
      S_DECODE: begin
        casez (op_code)
          6'b100011, 6'b101011: state_nx = S_MEM_ADDR;
          6'b000000, 6'b001???: state_nx = S_EXEC;
          6'b0001??, 6'b000001: state_nx = S_BRANCH;
          6'b000010:            state_nx = S_JUMP;
          6'b000011:            state_nx = S_JAL_WB;
          default:              state_nx = S_FAULT;
        endcase
      end
      S_MEM_ADDR: state_nx = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)    state_nx = S_MEM_WB;
        else if (tmo_hit) state_nx = S_FAULT;
      end
      S_MEM_WR: begin
        if (mem_ready)    state_nx = S_FETCH;
        else if (tmo_hit) state_nx = S_FAULT;
      end
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_JAL_WB: state_nx = S_FETCH;
      S_EXEC:  state_nx = S_ALU_WB;
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_FAULT;
    endcase
  end

  // Any state change is an entry into a new phase, so the watchdog restarts;
  // it only runs while a memory wait state is stalled.
  always_comb begin
    tmo_nx = tmo;
    if (state_nx != state) begin
      tmo_nx = '0;
    end else if (wait_st && !mem_ready && !tmo_hit) begin
      tmo_nx = tmo + TMO_W'(1);
    end
  end

  always_comb begin
    PCWr        = 1'b0;
    PCWrCond    = 1'b0;
    PCSrc       = 2'b00;
    IorD        = 1'b0;
    IRWr        = 1'b0;
    MemRd       = 1'b0;
    MemWr       = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 2'b00;
    RegWr       = 1'b0;
    RegPCWr     = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_ADD;
    sigext_high = 1'b0;
    fault       = 1'b0;
    // Holding reset forces every control output low, including the FETCH read.
    if (!rst) begin
      case (state)
        S_FETCH: begin
          MemRd   = 1'b1;
          ALUSrcB = 2'b01;
          if (mem_ready) begin
            IRWr = 1'b1;
            PCWr = 1'b1;
          end
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEM_RD: begin
          MemRd = 1'b1;
          IorD  = 1'b1;
        end
        S_MEM_WB: begin
          RegWr    = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEM_WR: begin
          MemWr = 1'b1;
          IorD  = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          if (op_q == OP_RR) begin
            ALUOp = ALU_R;
          end else begin
            ALUSrcB = 2'b10;
            case (op_q)
              OP_ADDI:  ALUOp = ALU_ADD;
              OP_ADDIU: ALUOp = ALU_ADDU;
              OP_SLTI:  ALUOp = ALU_SLT;
              OP_SLTIU: ALUOp = ALU_SLTU;
              OP_ANDI:  ALUOp = ALU_AND;
              OP_ORI:   ALUOp = ALU_OR;
              OP_XORI:  ALUOp = ALU_XOR;
              default:  ALUOp = ALU_ADD;
            endcase
            sigext_high = (op_q == OP_LUI);
          end
        end
        S_ALU_WB: begin
          RegWr       = 1'b1;
          RegDst      = (op_q == OP_RR) ? 2'b01 : 2'b00;
          sigext_high = (op_q == OP_LUI);
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALU_SUB;
          PCWrCond = 1'b1;
          PCSrc    = 2'b01;
        end
        S_JUMP: begin
          PCWr  = 1'b1;
          PCSrc = 2'b10;
        end
        S_JAL_WB: begin
          RegWr   = 1'b1;
          RegDst  = 2'b11;
          RegPCWr = 1'b1;
          PCWr    = 1'b1;
          PCSrc   = 2'b10;
        end
        S_FAULT: begin
          fault = 1'b1;
        end
        default: begin
          fault = 1'b1;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_mcu_multicycle.sv
// Bench for mcu_multicycle: per-instruction phase lists and an output table
// predict every cycle; directed cases followed by a randomized instruction mix.
module tb_mcu_multicycle;

  localparam int TMO_MAX = 200;

  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MW = 4, S_MWR = 5;
  localparam int S_EX = 6, S_AW = 7, S_BR = 8, S_J = 9, S_JW = 10, S_FLT = 11;

  localparam logic [3:0] A_ADD = 4'd0, A_ADDU = 4'd1, A_SUB = 4'd2, A_AND = 4'd3;
  localparam logic [3:0] A_OR = 4'd4, A_XOR = 4'd5, A_SLT = 4'd6, A_SLTU = 4'd7;
  localparam logic [3:0] A_R = 4'd8;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic [1:0] pc_src;
    logic       iord;
    logic       ir_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_wr;
    logic       reg_pc_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       sigext_high;
    logic       fault;
    logic [3:0] state;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op_code;
  logic       mem_ready;
  logic       PCWr, PCWrCond, IorD, IRWr, MemRd, MemWr, MemtoReg, RegWr, RegPCWr, ALUSrcA;
  logic [1:0] PCSrc, RegDst, ALUSrcB;
  logic [3:0] ALUOp;
  logic       sigext_high, fault;
  logic [3:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  mcu_multicycle #(.ALUOP_W(4), .TMO_W(8), .TMO_MAX(TMO_MAX)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .mem_ready(mem_ready),
    .PCWr(PCWr), .PCWrCond(PCWrCond), .PCSrc(PCSrc), .IorD(IorD), .IRWr(IRWr),
    .MemRd(MemRd), .MemWr(MemWr), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWr(RegWr), .RegPCWr(RegPCWr), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .sigext_high(sigext_high), .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] imm_alu(input logic [5:0] op);
    case (op)
      6'h08:   return A_ADD;
      6'h09:   return A_ADDU;
      6'h0a:   return A_SLT;
      6'h0b:   return A_SLTU;
      6'h0c:   return A_AND;
      6'h0d:   return A_OR;
      6'h0e:   return A_XOR;
      default: return A_ADD;
    endcase
  endfunction

  // Sequence of phases an instruction walks through; -1 marks the end.
  function automatic int phase(input logic [5:0] op, input int i);
    if (i == 0) return S_F;
    if (i == 1) return S_D;
    if (op == 6'h23) begin
      if (i == 2) return S_MA;
      if (i == 3) return S_MR;
      if (i == 4) return S_MW;
      return -1;
    end
    if (op == 6'h2b) begin
      if (i == 2) return S_MA;
      if (i == 3) return S_MWR;
      return -1;
    end
    if (op == 6'h00 || op[5:3] == 3'b001) begin
      if (i == 2) return S_EX;
      if (i == 3) return S_AW;
      return -1;
    end
    if (op[5:2] == 4'b0001 || op == 6'h01) return (i == 2) ? S_BR : -1;
    if (op == 6'h02) return (i == 2) ? S_J : -1;
    if (op == 6'h03) return (i == 2) ? S_JW : -1;
    return (i == 2) ? S_FLT : -1;
  endfunction

  function automatic ctl_t exp_out(input int st, input logic [5:0] op, input logic rdy);
    ctl_t e;
    e = '0;
    e.state = st[3:0];
    case (st)
      S_F: begin
        e.mem_rd = 1'b1; e.alu_src_b = 2'b01; e.alu_op = A_ADD;
        if (rdy) begin e.ir_wr = 1'b1; e.pc_wr = 1'b1; end
      end
      S_D:   begin e.alu_src_b = 2'b11; e.alu_op = A_ADD; end
      S_MA:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = A_ADD; end
      S_MR:  begin e.mem_rd = 1'b1; e.iord = 1'b1; end
      S_MW:  begin e.reg_wr = 1'b1; e.mem_to_reg = 1'b1; end
      S_MWR: begin e.mem_wr = 1'b1; e.iord = 1'b1; end
      S_EX: begin
        e.alu_src_a = 1'b1;
        if (op == 6'h00) e.alu_op = A_R;
        else begin
          e.alu_src_b = 2'b10; e.alu_op = imm_alu(op); e.sigext_high = (op == 6'h0f);
        end
      end
      S_AW: begin
        e.reg_wr = 1'b1; e.reg_dst = (op == 6'h00) ? 2'b01 : 2'b00;
        e.sigext_high = (op == 6'h0f);
      end
      S_BR: begin
        e.alu_src_a = 1'b1; e.alu_op = A_SUB; e.pc_wr_cond = 1'b1; e.pc_src = 2'b01;
      end
      S_J:  begin e.pc_wr = 1'b1; e.pc_src = 2'b10; end
      S_JW: begin
        e.reg_wr = 1'b1; e.reg_dst = 2'b11; e.reg_pc_wr = 1'b1; e.pc_wr = 1'b1; e.pc_src = 2'b10;
      end
      S_FLT: e.fault = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input ctl_t e);
    ctl_t got;
    got = {PCWr, PCWrCond, PCSrc, IorD, IRWr, MemRd, MemWr, MemtoReg, RegDst,
           RegWr, RegPCWr, ALUSrcA, ALUSrcB, ALUOp, sigext_high, fault, state_o};
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (state %0d vs %0d)", tag, got, e, got.state, e.state);
    end
  endtask

  // Drive inputs at the falling edge, check 1 time unit later, then wait one cycle.
  task automatic step(input logic r, input logic [5:0] opin, input int st,
                      input logic [5:0] mop, input string tag);
    mem_ready = r;
    op_code   = opin;
    #1;
    check(tag, exp_out(st, mop, r));
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    check({tag, "_assert"}, '0);
    @(negedge clk);
    check({tag, "_hold"}, '0);
    rst = 1'b0;
  endtask

  // fw/mw: ready-low cycles before ready in the fetch / data wait phase.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input string tag, output int faulted);
    int st;
    int lim;
    logic r;
    faulted = 0;
    for (int i = 0; phase(op, i) >= 0 && faulted == 0; i++) begin
      st = phase(op, i);
      if (st == S_F || st == S_MR || st == S_MWR) begin
        lim = (st == S_F) ? fw : mw;
        for (int w = 0; w <= TMO_MAX; w++) begin
          r = (w >= lim);
          step(r, 6'($urandom), st, op, tag);
          if (r) break;
          if (w == TMO_MAX) faulted = 1;
        end
      end else if (st == S_D) begin
        step(1'($urandom), op, S_D, op, tag);
      end else if (st == S_FLT) begin
        faulted = 1;
      end else begin
        step(1'($urandom), 6'($urandom), st, op, tag);
      end
    end
    if (faulted != 0) begin
      step(1'b1, 6'($urandom), S_FLT, op, {tag, "_fault"});
      step(1'b0, 6'($urandom), S_FLT, op, {tag, "_sticky"});
    end
  endtask

  logic [5:0] legal_ops [19] = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h09, 6'h0a, 6'h0b,
                                 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h04, 6'h05, 6'h06,
                                 6'h07, 6'h01, 6'h02, 6'h03, 6'h23};

  initial begin
    int flt;
    logic [5:0] op;
    rst = 1'b1;
    mem_ready = 1'b1;
    op_code = 6'h00;
    @(negedge clk);
    do_reset("reset");

    run_instr(6'h00, 0, 0, "rtype", flt);
    run_instr(6'h23, 0, 3, "lw_wait3", flt);
    run_instr(6'h03, 0, 0, "jal", flt);
    run_instr(6'h2b, 2, 1, "sw", flt);
    run_instr(6'h04, 0, 0, "beq", flt);
    run_instr(6'h02, 1, 0, "j", flt);
    run_instr(6'h0f, 0, 0, "lui", flt);
    run_instr(6'h0d, 0, 0, "ori", flt);
    run_instr(6'h01, 0, 0, "regimm", flt);

    run_instr(6'h3f, 0, 0, "illegal", flt);
    do_reset("illegal_rst");
    run_instr(6'h00, 0, 0, "after_illegal", flt);

    run_instr(6'h00, 1000, 0, "fetch_tmo", flt);
    do_reset("tmo_rst");
    run_instr(6'h00, TMO_MAX, 0, "fetch_ready_201", flt);
    run_instr(6'h23, 0, 1000, "memrd_tmo", flt);
    do_reset("memrd_rst");
    run_instr(6'h2b, 0, TMO_MAX, "memwr_ready_201", flt);

    // Asynchronous reset in the middle of an ADDI EXEC cycle.
    step(1'b1, 6'($urandom), S_F, 6'h08, "abort");
    step(1'b1, 6'h08, S_D, 6'h08, "abort");
    mem_ready = 1'b1;
    op_code = 6'($urandom);
    #1;
    check("abort_exec", exp_out(S_EX, 6'h08, 1'b1));
    #2;
    rst = 1'b1;
    #1;
    check("abort_async", '0);
    @(negedge clk);
    check("abort_hold", '0);
    rst = 1'b0;
    run_instr(6'h08, 0, 0, "abort_resume", flt);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 18)];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), "random", flt);
      if (flt != 0) do_reset("random_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
